// File: rtl/ram_bist_pkg.sv
// Shared types, constants and data-pattern helper for the RAM self-test controller.
package ram_bist_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 16;

  localparam logic PHASE_TRUE = 1'b0;
  localparam logic PHASE_INV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  // Address is zero-extended by the caller; the inverse pass flips every bit.
  function automatic logic [DW_DEF-1:0] pat(input logic [DW_DEF-1:0] seed,
                                            input logic [DW_DEF-1:0] addr,
                                            input logic              phase);
    logic [DW_DEF-1:0] v;
    v = seed ^ addr;
    return phase ? ~v : v;
  endfunction

endpackage

// File: rtl/ram_bist_lat_cnt.sv
// Loadable read-latency down-counter; o_expire marks the cycle the read data is valid.
module ram_bist_lat_cnt #(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_expire
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/ram_bist_ctrl.sv
// Two-pass RAM self-test: write pattern, read-compare, write inverse, read-compare.
// state       | meaning
// ST_IDLE     | waiting for start; results of last run held
// ST_WR       | one write per address, current phase pattern
// ST_RD_ISSUE | single-cycle read request for current address
// ST_RD_WAIT  | waiting RD_LAT cycles, compare on expire
// ST_DONE     | one-cycle done pulse, pass valid
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int              AW     = AW_DEF,
  parameter int              DW     = DW_DEF,
  parameter int              RD_LAT = 1,
  parameter logic [DW-1:0]   SEED   = 16'hA5C3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] din,
  output logic          re,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          fail_phase
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_phase;

  logic          w_cnt_load;
  logic          w_expire;
  logic [AW-1:0] w_addr_inc;
  logic          w_miss;
  logic [AW+1:0] w_err_nxt;

  function automatic logic [DW-1:0] pat_at(input logic [AW-1:0] a, input logic p);
    return pat(SEED, {{(DW-AW){1'b0}}, a}, p);
  endfunction

  assign w_cnt_load = (r_state == ST_RD_ISSUE);
  assign w_addr_inc = r_addr + 1'b1;
  assign w_miss     = (dout != pat_at(r_addr, r_phase));
  assign w_err_nxt  = err_cnt + {{(AW+1){1'b0}}, w_miss};

  ram_bist_lat_cnt #(
    .LAT (RD_LAT)
  ) u_lat_cnt (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_load   (w_cnt_load),
    .o_expire (w_expire)
  );

  // Outputs are loaded on the edge that enters each state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_phase    <= PHASE_TRUE;
      we         <= 1'b0;
      waddr      <= '0;
      din        <= '0;
      re         <= 1'b0;
      raddr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      fail_phase <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_WR;
            r_addr     <= '0;
            r_phase    <= PHASE_TRUE;
            we         <= 1'b1;
            waddr      <= '0;
            din        <= pat_at('0, PHASE_TRUE);
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_phase <= PHASE_TRUE;
          end
        end
        ST_WR: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_RD_ISSUE;
            r_addr  <= '0;
            we      <= 1'b0;
            re      <= 1'b1;
            raddr   <= '0;
          end else begin
            r_addr <= w_addr_inc;
            waddr  <= w_addr_inc;
            din    <= pat_at(w_addr_inc, r_phase);
          end
        end
        ST_RD_ISSUE: begin
          re      <= 1'b0;
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_expire) begin
            if (w_miss) begin
              err_cnt <= w_err_nxt;
              if (err_cnt == '0) begin
                fail_addr  <= r_addr;
                fail_phase <= r_phase;
              end
            end
            if (r_addr != LAST_ADDR) begin
              r_addr  <= w_addr_inc;
              re      <= 1'b1;
              raddr   <= w_addr_inc;
              r_state <= ST_RD_ISSUE;
            end else if (r_phase == PHASE_TRUE) begin
              r_phase <= PHASE_INV;
              r_addr  <= '0;
              we      <= 1'b1;
              waddr   <= '0;
              din     <= pat_at('0, PHASE_INV);
              r_state <= ST_WR;
            end else begin
              done    <= 1'b1;
              busy    <= 1'b0;
              pass    <= (w_err_nxt == '0);
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (read latency 1 and 3), each with a faultable RAM model.
module tb_ram_bist_ctrl;

  logic        clk;
  logic        rst;
  logic        start_v   [2];
  logic        we_v      [2];
  logic [2:0]  waddr_v   [2];
  logic [15:0] din_v     [2];
  logic        re_v      [2];
  logic [2:0]  raddr_v   [2];
  logic [15:0] dout_v    [2];
  logic        busy_v    [2];
  logic        done_v    [2];
  logic        pass_v    [2];
  logic [4:0]  err_v     [2];
  logic [2:0]  fa_v      [2];
  logic        fp_v      [2];

  // fault model: 0 = ideal, 1 = one stored bit stuck, 2 = dout tied to zero
  int f_mode [2];
  int f_addr [2];
  int f_bit  [2];
  int f_val  [2];

  logic [15:0] mem  [2][8];
  logic [15:0] pipe [2][4];

  int n_checks = 0;
  int n_pass   = 0;

  int lat_m [2];
  int t_m   [2];
  bit vis_pass [2];
  int vis_err [2], vis_fa [2], vis_fp [2];
  int fin_err [2], fin_fa [2], fin_fp [2];
  logic [15:0] seen3 [2][2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    ram_bist_ctrl #(
      .AW(3), .DW(16), .RD_LAT(LAT), .SEED(16'hA5C3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .we         (we_v[g]),
      .waddr      (waddr_v[g]),
      .din        (din_v[g]),
      .re         (re_v[g]),
      .raddr      (raddr_v[g]),
      .dout       (dout_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .pass       (pass_v[g]),
      .err_cnt    (err_v[g]),
      .fail_addr  (fa_v[g]),
      .fail_phase (fp_v[g])
    );
    assign dout_v[g] = (f_mode[g] == 2) ? 16'h0000 : pipe[g][LAT-1];
  end

  function automatic logic [15:0] mpat(input int a, input int p);
    logic [15:0] v;
    v = 16'hA5C3 ^ 16'(a);
    if (p != 0) v = ~v;
    return v;
  endfunction

  function automatic logic [15:0] stored(input int g, input int a, input logic [15:0] d);
    logic [15:0] v;
    v = d;
    if (f_mode[g] == 1 && a == f_addr[g]) v[f_bit[g]] = f_val[g][0];
    return v;
  endfunction

  function automatic int run_len(input int g);
    return 2 * (8 + 8 * (1 + lat_m[g])) + 1;
  endfunction

  // RAM: write on we, read data emerges RD_LAT edges after re is sampled
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (we_v[g]) mem[g][waddr_v[g]] <= stored(g, int'(waddr_v[g]), din_v[g]);
      for (int s = 3; s > 0; s--) pipe[g][s] <= pipe[g][s-1];
      if (re_v[g]) pipe[g][0] <= mem[g][raddr_v[g]];
    end
  end

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst=%0d t=%0d: got %0h expected %0h", nm, g, t_m[g], act, exp);
  endtask

  task automatic clear_vis(input int g);
    vis_pass[g] = 1'b0;
    vis_err[g]  = 0;
    vis_fa[g]   = 0;
    vis_fp[g]   = 0;
  endtask

  // Expected result of a whole run from the fault model, scanned in test order.
  task automatic compute_fin(input int g);
    logic [15:0] e, got;
    fin_err[g] = 0; fin_fa[g] = 0; fin_fp[g] = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        e   = mpat(a, p);
        got = (f_mode[g] == 2) ? 16'h0000 : stored(g, a, e);
        if (got != e) begin
          if (fin_err[g] == 0) begin
            fin_fa[g] = a;
            fin_fp[g] = p;
          end
          fin_err[g]++;
        end
      end
    end
  endtask

  task automatic model_step(input int g);
    if (!rst) begin
      t_m[g] = 0;
      clear_vis(g);
    end else if (t_m[g] == 0) begin
      if (start_v[g]) begin
        t_m[g] = 1;
        clear_vis(g);
        compute_fin(g);
      end
    end else if (t_m[g] < run_len(g)) begin
      t_m[g]++;
      if (t_m[g] == run_len(g)) begin
        vis_pass[g] = (fin_err[g] == 0);
        vis_err[g]  = fin_err[g];
        vis_fa[g]   = fin_fa[g];
        vis_fp[g]   = fin_fp[g];
      end
    end else begin
      t_m[g] = 0;
    end
  endtask

  // Window t of a run: phase blocks of 8 writes then 8 reads of (1 + latency) cycles.
  task automatic check_inst(input int g);
    int L, seg, tt, t, ph, o, r, a;
    bit ewe, ere, ebusy, edone;
    L = lat_m[g]; seg = 8 + 8 * (1 + L); tt = run_len(g); t = t_m[g];
    ewe = 0; ere = 0; ebusy = 0; edone = 0; ph = 0; a = 0;
    if (t == tt) begin
      edone = 1;
    end else if (t > 0) begin
      ebusy = 1;
      ph = (t - 1) / seg;
      o  = (t - 1) % seg;
      if (o < 8) begin
        ewe = 1; a = o;
      end else begin
        r = o - 8; a = r / (1 + L); ere = ((r % (1 + L)) == 0);
      end
    end
    chk("we", g, we_v[g], ewe);
    chk("re", g, re_v[g], ere);
    chk("busy", g, busy_v[g], ebusy);
    chk("done", g, done_v[g], edone);
    chk("pass", g, pass_v[g], vis_pass[g]);
    if (ewe) begin
      chk("waddr", g, waddr_v[g], a);
      chk("din", g, din_v[g], mpat(a, ph));
      if (a == 3) seen3[g][ph] = din_v[g];
    end
    if (ere) chk("raddr", g, raddr_v[g], a);
    if (t == 0 || t == 1 || t == tt) begin
      chk("err_cnt", g, err_v[g], vis_err[g]);
      chk("fail_addr", g, fa_v[g], vis_fa[g]);
      chk("fail_phase", g, fp_v[g], vis_fp[g]);
    end
    if (!rst) begin
      chk("rst_waddr", g, waddr_v[g], 0);
      chk("rst_raddr", g, raddr_v[g], 0);
      chk("rst_din", g, din_v[g], 0);
    end
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) model_step(g);
    #1;
    for (int g = 0; g < 2; g++) check_inst(g);
  end

  task automatic set_fault(input int g, input int m, input int a, input int b, input int v);
    f_mode[g] = m; f_addr[g] = a; f_bit[g] = b; f_val[g] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      start_v[1] = 1'b0;
    end
  endtask

  // Start a run on instance g, optionally re-pulse start in windows sa/sb, return at done.
  task automatic do_run(input int g, input int sa, input int sb,
                        output int len, output int nre, output int nboth);
    bit got;
    @(negedge clk);
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    start_v[g] = 1'b1;
    len = 0; nre = 0; nboth = 0; got = 0;
    while (len < 400 && !got) begin
      @(negedge clk);
      len++;
      start_v[g] = (len == sa || len == sb);
      if (re_v[g]) nre++;
      if (we_v[g] && re_v[g]) nboth++;
      if (len == 1) begin
        chk("busy_after_start", g, busy_v[g], 1);
        chk("err_cleared", g, err_v[g], 0);
      end
      if (done_v[g]) got = 1;
    end
    if (!got) chk("done_timeout", g, len, run_len(g));
  endtask

  initial begin
    int len, nre, nboth, g, sa, sb, exp_len, w;
    lat_m[0] = 1; lat_m[1] = 3;
    t_m[0] = 0; t_m[1] = 0;
    clear_vis(0); clear_vis(1);
    set_fault(0, 0, 0, 0, 0);
    set_fault(1, 0, 0, 0, 0);
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // fault-free, with ignored starts mid-run and in the done cycle
    for (int i = 0; i < 2; i++) begin seen3[0][i] = '0; end
    do_run(0, 10, 49, len, nre, nboth);
    chk("len_lat1", 0, len, 49);
    chk("re_pulses", 0, nre, 16);
    chk("we_re_overlap", 0, nboth, 0);
    chk("ideal_pass", 0, pass_v[0], 1);
    chk("ideal_err", 0, err_v[0], 0);
    chk("din_a3_p0", 0, seen3[0][0], 16'hA5C0);
    chk("din_a3_p1", 0, seen3[0][1], 16'h5A3F);
    idle(3);
    chk("no_restart", 0, busy_v[0], 0);

    // bit 0 of address 5 stuck at 0
    set_fault(0, 1, 5, 0, 0);
    do_run(0, 0, 0, len, nre, nboth);
    chk("stuck_pass", 0, pass_v[0], 0);
    chk("stuck_err", 0, err_v[0], 1);
    chk("stuck_addr", 0, fa_v[0], 5);
    chk("stuck_phase", 0, fp_v[0], 1);

    // start one cycle after done; dead RAM
    set_fault(0, 2, 0, 0, 0);
    do_run(0, 0, 0, len, nre, nboth);
    chk("dead_pass", 0, pass_v[0], 0);
    chk("dead_err", 0, err_v[0], 16);
    chk("dead_addr", 0, fa_v[0], 0);
    chk("dead_phase", 0, fp_v[0], 0);
    idle(2);

    // read latency 3
    set_fault(1, 0, 0, 0, 0);
    do_run(1, 0, 0, len, nre, nboth);
    chk("len_lat3", 1, len, 81);
    chk("re_pulses_lat3", 1, nre, 16);
    chk("we_re_overlap_lat3", 1, nboth, 0);
    chk("lat3_pass", 1, pass_v[1], 1);
    idle(1);

    // random faults, instances, spurious starts and gaps
    for (int i = 0; i < 10; i++) begin
      g = $urandom_range(0, 1);
      set_fault(g, $urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 1));
      exp_len = (g == 0) ? 49 : 81;
      sa = $urandom_range(0, exp_len);
      sb = $urandom_range(0, exp_len);
      idle($urandom_range(0, 2));
      do_run(g, sa, sb, len, nre, nboth);
      chk("rand_len", g, len, exp_len);
      chk("rand_re_pulses", g, nre, 16);
    end
    idle(2);

    // asynchronous reset during phase-1 reads of a failing run
    set_fault(0, 2, 0, 0, 0);
    @(negedge clk);
    start_v[0] = 1'b1;
    w = 0;
    while (w < 41) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      w++;
    end
    chk("pre_rst_re", 0, re_v[0], 1);
    #2 rst = 1'b0;
    #1;
    chk("async_we", 0, we_v[0], 0);
    chk("async_re", 0, re_v[0], 0);
    chk("async_busy", 0, busy_v[0], 0);
    chk("async_pass", 0, pass_v[0], 0);
    chk("async_err", 0, err_v[0], 0);
    @(negedge clk);
    rst = 1'b1;
    idle(6);
    chk("post_rst_idle", 0, busy_v[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
